// File: rtl/clint_pkg.sv
// Shared definitions for the CLINT bus front end.
// Address map offsets, decode kinds, FSM states and byte-merge helper.
package clint_pkg;

    localparam int unsigned IDX_W = 12;

    localparam logic [31:0] CLINT_MSIP_BASE     = 32'h0000_0000;
    localparam logic [31:0] CLINT_MTIMECMP_BASE = 32'h0000_4000;
    localparam logic [31:0] CLINT_MTIME_OFF     = 32'h0000_BFF8;

    typedef enum logic [1:0] {
        MSIP,
        MTIMECMP,
        MTIME,
        ERR
    } dec_kind_e;

    typedef enum logic {
        ST_IDLE,
        ST_RESP
    } state_e;

    function automatic logic [63:0] byte_merge(
        input logic [63:0] old_v,
        input logic [63:0] new_v,
        input logic [7:0]  strb
    );
        logic [63:0] r;
        for (int b = 0; b < 8; b++) begin
            r[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/clint_addr_dec.sv
// CLINT address decoder.
// Maps a byte offset to register kind and hart index; flags holes and absent harts.
module clint_addr_dec
    import clint_pkg::*;
#(
    parameter int unsigned HART_NUM = 1,
    parameter int unsigned ADDR_W   = 16
) (
    input  logic [ADDR_W-1:0] req_addr,
    output dec_kind_e         kind,
    output logic [IDX_W-1:0]  hart,
    output logic              err
);

    logic [31:0] a;

    // Classify the 8-byte word; msip words report their even hart.
    always_comb begin
        a    = 32'(req_addr) & ~32'h7;
        kind = ERR;
        hart = '0;
        if (a < CLINT_MTIMECMP_BASE) begin
            kind = MSIP;
            hart = {a[13:3], 1'b0};
        end else if (a == CLINT_MTIME_OFF) begin
            kind = MTIME;
        end else if (a < CLINT_MTIME_OFF) begin
            kind = MTIMECMP;
            hart = IDX_W'(a[15:3] - 13'h0800);
        end
        if ((kind == MSIP || kind == MTIMECMP) && 32'(hart) >= HART_NUM) begin
            kind = ERR;
        end
        err = (kind == ERR);
    end

endmodule

// File: rtl/clint_reg_if.sv
// CLINT bus front end: request/response FSM, write strobes, read capture
// and rtc tick folding into the shared core write port.
module clint_reg_if
    import clint_pkg::*;
#(
    parameter int unsigned HART_NUM = 1,
    parameter int unsigned ADDR_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rtc_tick,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [63:0]              req_wdata,
    input  logic [7:0]               req_wstrb,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [63:0]              rsp_rdata,
    output logic                     rsp_err,
    input  logic [63:0]              mtime,
    input  logic [64*HART_NUM-1:0]   mtimecmp,
    input  logic [HART_NUM-1:0]      msip,
    output logic                     mtime_wen,
    output logic [HART_NUM-1:0]      mtimecmp_wen,
    output logic [HART_NUM-1:0]      msip_wen,
    output logic [63:0]              reg_wdata
);

    state_e            state_q, state_d;
    logic              tick_pend_q, tick_pend_d;
    logic [63:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    dec_kind_e         kind;
    logic [IDX_W-1:0]  hart;
    logic [IDX_W-1:0]  hart_odd;
    logic              dec_err;
    logic              wr;
    logic              commit;
    logic [63:0]       cmp_old;
    logic              msip_lo;
    logic              msip_hi;

    clint_addr_dec #(
        .HART_NUM (HART_NUM),
        .ADDR_W   (ADDR_W)
    ) u_dec (
        .req_addr (req_addr),
        .kind     (kind),
        .hart     (hart),
        .err      (dec_err)
    );

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign hart_odd  = hart + IDX_W'(1);
    assign wr        = req_ready && req_valid && req_write;

    // Current core values for the decoded hart(s); absent harts read 0.
    always_comb begin
        cmp_old = '0;
        msip_lo = 1'b0;
        msip_hi = 1'b0;
        for (int i = 0; i < HART_NUM; i++) begin
            if (hart == IDX_W'(i)) begin
                cmp_old = mtimecmp[64*i +: 64];
                msip_lo = msip[i];
            end
            if (hart_odd == IDX_W'(i)) begin
                msip_hi = msip[i];
            end
        end
    end

    // Core write port: bus commit first, otherwise drain a pending tick.
    always_comb begin
        mtime_wen    = 1'b0;
        mtimecmp_wen = '0;
        msip_wen     = '0;
        reg_wdata    = '0;
        tick_pend_d  = tick_pend_q | rtc_tick;
        if (wr) begin
            unique case (kind)
                MTIME: begin
                    mtime_wen = |req_wstrb;
                    reg_wdata = byte_merge(mtime, req_wdata, req_wstrb);
                end
                MTIMECMP: begin
                    reg_wdata = byte_merge(cmp_old, req_wdata, req_wstrb);
                    for (int i = 0; i < HART_NUM; i++) begin
                        if (hart == IDX_W'(i)) mtimecmp_wen[i] = |req_wstrb;
                    end
                end
                MSIP: begin
                    reg_wdata = req_wdata;
                    for (int i = 0; i < HART_NUM; i++) begin
                        if (hart == IDX_W'(i))     msip_wen[i] = req_wstrb[0];
                        if (hart_odd == IDX_W'(i)) msip_wen[i] = req_wstrb[4];
                    end
                end
                default: ;
            endcase
        end
        commit = mtime_wen | (|mtimecmp_wen) | (|msip_wen);
        if (mtime_wen) begin
            tick_pend_d = 1'b0;
        end else if (!commit && tick_pend_q) begin
            mtime_wen   = 1'b1;
            reg_wdata   = mtime + 64'd1;
            tick_pend_d = rtc_tick;
        end
    end

    // Handshake FSM and response capture on accept.
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = ST_RESP;
                    err_d   = dec_err;
                    rdata_d = '0;
                    if (!req_write) begin
                        unique case (kind)
                            MSIP:     rdata_d = {31'b0, msip_hi, 31'b0, msip_lo};
                            MTIMECMP: rdata_d = cmp_old;
                            MTIME:    rdata_d = mtime;
                            default:  rdata_d = '0;
                        endcase
                    end
                end
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, response and tick-pending registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tick_pend_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_pend_q <= tick_pend_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_clint_reg_if.sv
// Directed bench for clint_reg_if with a behavioural CLINT core model.
// Three harts so both the odd-hart gate and index errors are reachable.
module tb_clint_reg_if;

    localparam int unsigned HN = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rtc_tick;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [15:0]   req_addr;
    logic [63:0]   req_wdata;
    logic [7:0]    req_wstrb;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [63:0]   rsp_rdata;
    logic          rsp_err;
    logic          mtime_wen;
    logic [HN-1:0] mtimecmp_wen;
    logic [HN-1:0] msip_wen;
    logic [63:0]   reg_wdata;

    logic [63:0]   c_mtime;
    logic [63:0]   c_cmp [HN];
    logic [HN-1:0] c_msip;
    logic [64*HN-1:0] cmp_flat;

    logic          ld_en;
    logic          ld_sel;
    logic [63:0]   ld_val;

    logic          s_mtime_wen;
    logic [HN-1:0] s_cmp_wen;
    logic [HN-1:0] s_msip_wen;
    logic [63:0]   s_wdata;
    logic          s_ready;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    assign cmp_flat = {c_cmp[2], c_cmp[1], c_cmp[0]};

    clint_reg_if #(
        .HART_NUM (HN),
        .ADDR_W   (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rtc_tick     (rtc_tick),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_wstrb    (req_wstrb),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mtime        (c_mtime),
        .mtimecmp     (cmp_flat),
        .msip         (c_msip),
        .mtime_wen    (mtime_wen),
        .mtimecmp_wen (mtimecmp_wen),
        .msip_wen     (msip_wen),
        .reg_wdata    (reg_wdata)
    );

    // CLINT register core model: even harts take bit 0, odd harts bit 32.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_mtime <= '0;
            c_msip  <= '0;
            for (int i = 0; i < HN; i++) c_cmp[i] <= '0;
        end else if (ld_en) begin
            if (ld_sel) c_cmp[0] <= ld_val;
            else        c_mtime  <= ld_val;
        end else begin
            if (mtime_wen) c_mtime <= reg_wdata;
            for (int i = 0; i < HN; i++) begin
                if (mtimecmp_wen[i]) c_cmp[i] <= reg_wdata;
                if (msip_wen[i]) c_msip[i] <= (i % 2 == 0) ? reg_wdata[0] : reg_wdata[32];
            end
        end
    end

    task automatic preload(input logic sel, input logic [63:0] v);
        @(negedge clk);
        ld_en = 1'b1; ld_sel = sel; ld_val = v;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // One request from IDLE; snapshots write-port outputs in the accept cycle.
    task automatic issue(input logic w, input logic [15:0] a, input logic [63:0] d,
                         input logic [7:0] s, input logic t);
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a;
        req_wdata = d; req_wstrb = s; rtc_tick = t;
        #1;
        s_mtime_wen = mtime_wen; s_cmp_wen = mtimecmp_wen;
        s_msip_wen = msip_wen; s_wdata = reg_wdata; s_ready = req_ready;
        @(negedge clk);
        req_valid = 1'b0; rtc_tick = 1'b0;
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        vectors++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", req_ready); end
        vectors++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", rsp_valid); end
        vectors++; if (rsp_rdata !== 64'd0 || rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp got %h/%b want 0/0", rsp_rdata, rsp_err); end
        vectors++; if (mtime_wen !== 1'b0 || mtimecmp_wen !== 3'b0 || msip_wen !== 3'b0 || reg_wdata !== 64'd0) begin
            errors++; $display("FAIL rst_wport got %b %b %b %h want all 0", mtime_wen, mtimecmp_wen, msip_wen, reg_wdata); end
    endtask

    task automatic test_mtime_rw();
        issue(1'b1, 16'hBFF8, 64'h1234_5678_9ABC_DEF0, 8'hFF, 1'b0);
        vectors++; if (s_ready !== 1'b1 || s_mtime_wen !== 1'b1 || s_wdata !== 64'h1234_5678_9ABC_DEF0) begin
            errors++; $display("FAIL mtime_wr got rdy=%b wen=%b d=%h want 1 1 123456789abcdef0", s_ready, s_mtime_wen, s_wdata); end
        vectors++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 64'd0) begin
            errors++; $display("FAIL mtime_wr_rsp got v=%b e=%b d=%h want 1 0 0", rsp_valid, rsp_err, rsp_rdata); end
        vectors++; if (c_mtime !== 64'h1234_5678_9ABC_DEF0) begin errors++; $display("FAIL mtime_core got %h want 123456789abcdef0", c_mtime); end
        finish_rsp();
        issue(1'b0, 16'hBFF8, 64'd0, 8'hFF, 1'b0);
        vectors++; if (s_mtime_wen !== 1'b0) begin errors++; $display("FAIL mtime_rd_wen got %b want 0", s_mtime_wen); end
        vectors++; if (rsp_rdata !== 64'h1234_5678_9ABC_DEF0 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL mtime_rd got %h/%b want 123456789abcdef0/0", rsp_rdata, rsp_err); end
        finish_rsp();
    endtask

    task automatic test_msip();
        issue(1'b1, 16'h0000, 64'h0000_0001_0000_0001, 8'h11, 1'b0);
        vectors++; if (s_msip_wen !== 3'b011 || s_wdata !== 64'h0000_0001_0000_0001) begin
            errors++; $display("FAIL msip0_wr got wen=%b d=%h want 011 0000000100000001", s_msip_wen, s_wdata); end
        vectors++; if (c_msip !== 3'b011) begin errors++; $display("FAIL msip0_core got %b want 011", c_msip); end
        finish_rsp();
        issue(1'b0, 16'h0004, 64'd0, 8'h00, 1'b0);
        vectors++; if (rsp_rdata !== 64'h0000_0001_0000_0001 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL msip0_rd got %h/%b want 0000000100000001/0", rsp_rdata, rsp_err); end
        finish_rsp();
        issue(1'b1, 16'h0008, 64'h0000_0001_0000_0001, 8'h11, 1'b0);
        vectors++; if (s_msip_wen !== 3'b100) begin errors++; $display("FAIL msip1_gate got %b want 100", s_msip_wen); end
        finish_rsp();
        issue(1'b0, 16'h0008, 64'd0, 8'h00, 1'b0);
        vectors++; if (rsp_rdata !== 64'h0000_0000_0000_0001 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL msip1_rd got %h/%b want 0000000000000001/0", rsp_rdata, rsp_err); end
        finish_rsp();
    endtask

    task automatic test_merge();
        preload(1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        issue(1'b1, 16'h4000, 64'hAAAA_AAAA_5555_5555, 8'h0F, 1'b0);
        vectors++; if (s_cmp_wen !== 3'b001 || s_wdata !== 64'hFFFF_FFFF_5555_5555) begin
            errors++; $display("FAIL cmp_merge got wen=%b d=%h want 001 ffffffff55555555", s_cmp_wen, s_wdata); end
        finish_rsp();
        issue(1'b1, 16'h4010, 64'h1, 8'h00, 1'b0);
        vectors++; if (s_cmp_wen !== 3'b000 || s_mtime_wen !== 1'b0 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL cmp_nostrb got wen=%b mt=%b e=%b want 000 0 0", s_cmp_wen, s_mtime_wen, rsp_err); end
        finish_rsp();
        issue(1'b0, 16'h4000, 64'd0, 8'h00, 1'b0);
        vectors++; if (rsp_rdata !== 64'hFFFF_FFFF_5555_5555) begin
            errors++; $display("FAIL cmp_rd got %h want ffffffff55555555", rsp_rdata); end
        finish_rsp();
    endtask

    task automatic test_tick_wrap();
        preload(1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        rtc_tick = 1'b1;
        @(negedge clk);
        rtc_tick = 1'b0;
        #1;
        vectors++; if (mtime_wen !== 1'b1 || reg_wdata !== 64'd0) begin
            errors++; $display("FAIL tick_wrap_port got wen=%b d=%h want 1 0", mtime_wen, reg_wdata); end
        @(negedge clk);
        #1;
        vectors++; if (c_mtime !== 64'd0 || mtime_wen !== 1'b0) begin
            errors++; $display("FAIL tick_wrap got mtime=%h wen=%b want 0 0", c_mtime, mtime_wen); end
    endtask

    task automatic test_tick_contention();
        preload(1'b0, 64'd100);
        rtc_tick = 1'b1;
        issue(1'b1, 16'h4008, 64'h77, 8'hFF, 1'b0);
        vectors++; if (s_mtime_wen !== 1'b0 || s_cmp_wen !== 3'b010 || s_wdata !== 64'h77) begin
            errors++; $display("FAIL tick_vs_cmp got mt=%b cw=%b d=%h want 0 010 77", s_mtime_wen, s_cmp_wen, s_wdata); end
        #1;
        vectors++; if (c_mtime !== 64'd100 || mtime_wen !== 1'b1 || reg_wdata !== 64'd101) begin
            errors++; $display("FAIL tick_deferred got mtime=%0d wen=%b d=%0d want 100 1 101", c_mtime, mtime_wen, reg_wdata); end
        @(negedge clk);
        vectors++; if (c_mtime !== 64'd101) begin errors++; $display("FAIL tick_late got %0d want 101", c_mtime); end
        finish_rsp();
        issue(1'b1, 16'hBFF8, 64'd5, 8'hFF, 1'b1);
        vectors++; if (s_mtime_wen !== 1'b1 || s_wdata !== 64'd5) begin
            errors++; $display("FAIL tick_vs_mtime got wen=%b d=%0d want 1 5", s_mtime_wen, s_wdata); end
        #1;
        vectors++; if (c_mtime !== 64'd5 || mtime_wen !== 1'b0) begin
            errors++; $display("FAIL tick_dropped got mtime=%0d wen=%b want 5 0", c_mtime, mtime_wen); end
        @(negedge clk);
        vectors++; if (c_mtime !== 64'd5) begin errors++; $display("FAIL tick_dropped2 got %0d want 5", c_mtime); end
        finish_rsp();
    endtask

    task automatic test_error_hold();
        issue(1'b0, 16'h8000, 64'd0, 8'hFF, 1'b0);
        vectors++; if (rsp_err !== 1'b1 || rsp_rdata !== 64'd0 || rsp_valid !== 1'b1) begin
            errors++; $display("FAIL err_8000 got e=%b d=%h v=%b want 1 0 1", rsp_err, rsp_rdata, rsp_valid); end
        for (int c = 0; c < 3; c++) begin
            req_valid = 1'b1; req_write = 1'b1; req_addr = 16'hBFF8;
            req_wdata = 64'h99; req_wstrb = 8'hFF;
            #1;
            vectors++; if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 64'd0 || mtime_wen !== 1'b0) begin
                errors++; $display("FAIL hold%0d got rdy=%b v=%b e=%b d=%h wen=%b want 0 1 1 0 0",
                                   c, req_ready, rsp_valid, rsp_err, rsp_rdata, mtime_wen); end
            @(negedge clk);
        end
        req_valid = 1'b0;
        finish_rsp();
        issue(1'b0, 16'h4018, 64'd0, 8'h00, 1'b0);
        vectors++; if (rsp_err !== 1'b1 || rsp_rdata !== 64'd0) begin
            errors++; $display("FAIL err_cmp3 got e=%b d=%h want 1 0", rsp_err, rsp_rdata); end
        finish_rsp();
        issue(1'b1, 16'h4018, 64'h5, 8'hFF, 1'b0);
        vectors++; if (s_cmp_wen !== 3'b000 || s_mtime_wen !== 1'b0 || rsp_err !== 1'b1) begin
            errors++; $display("FAIL err_cmp3_wr got cw=%b mt=%b e=%b want 000 0 1", s_cmp_wen, s_mtime_wen, rsp_err); end
        finish_rsp();
        issue(1'b1, 16'h0010, 64'h1, 8'hFF, 1'b0);
        vectors++; if (s_msip_wen !== 3'b000 || rsp_err !== 1'b1) begin
            errors++; $display("FAIL err_msip2 got w=%b e=%b want 000 1", s_msip_wen, rsp_err); end
        finish_rsp();
        issue(1'b0, 16'hBFF0, 64'd0, 8'h00, 1'b0);
        vectors++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL err_bff0 got %b want 1", rsp_err); end
        finish_rsp();
    endtask

    task automatic test_reset_mid();
        issue(1'b0, 16'hBFF8, 64'd0, 8'h00, 1'b0);
        rtc_tick = 1'b1;
        @(negedge clk);
        rtc_tick = 1'b0;
        rst_n = 1'b0;
        #1;
        vectors++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mtime_wen !== 1'b0) begin
            errors++; $display("FAIL rst_mid got v=%b rdy=%b wen=%b want 0 1 0", rsp_valid, req_ready, mtime_wen); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++; if (mtime_wen !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rst_tick_lost got wen=%b v=%b want 0 0", mtime_wen, rsp_valid); end
    endtask

    initial begin
        rst_n = 1'b0; rtc_tick = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_addr = '0; req_wdata = '0; req_wstrb = '0; rsp_ready = 1'b0;
        ld_en = 1'b0; ld_sel = 1'b0; ld_val = '0;
        @(negedge clk);
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_mtime_rw();
        test_msip();
        test_merge();
        test_tick_wrap();
        test_tick_contention();
        test_error_hold();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/clint_reg_if.md
# clint_reg_if

Bus-side front end for the CLINT timer/IPI register core. It accepts single-beat read/write requests on a 64-bit valid/ready bus, decodes the CLINT address map, and drives the core's write strobes and shared write-data bus. It returns read data and error status, and advances `mtime` on real-time ticks. It sits between the SoC interconnect slave port and the CLINT register core.

## Interface
- `HART_NUM`, 1, number of harts; legal range 1–4095.
- `ADDR_W`, 16, width of the byte offset inside the CLINT window.
- `clk` in 1: the single clock for the block.
- `rst_n` in 1: asynchronous, active-low reset.
- `rtc_tick` in 1: one-cycle pulse, synchronous to `clk`; each pulse increments `mtime` by 1.
- `req_valid` in 1 / `req_ready` out 1: request handshake.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in `ADDR_W`: byte offset; bits [2:0] are ignored.
- `req_wdata` in 64: write data.
- `req_wstrb` in 8: byte enables; ignored for reads.
- `rsp_valid` out 1 / `rsp_ready` in 1: response handshake.
- `rsp_rdata` out 64: read data; 0 for writes and errors.
- `rsp_err` out 1: 1 = unmapped address or hart index ≥ `HART_NUM`.
- `mtime` in 64, `mtimecmp` in 64·`HART_NUM`, `msip` in `HART_NUM`: current core state.
- `mtime_wen` out 1, `mtimecmp_wen` out `HART_NUM`, `msip_wen` out `HART_NUM`, `reg_wdata` out 64: core write port.

## Operation
- **Address map** (8-byte words):
  - msip: 0x0000 + 8k. Lower half is hart 2k (bit 0); upper half is hart 2k+1 (bit 32).
  - mtimecmp[i]: 0x4000 + 8i.
  - mtime: 0xBFF8.
  - Everything else is an error.
- **FSM, two states:**
  - IDLE: `req_ready`=1.
  - RESP: `req_ready`=0, `rsp_valid`=1.
  - IDLE→RESP when `req_valid`.
  - RESP→IDLE when `rsp_ready`.
- **Write commit** happens combinationally in the accept cycle (IDLE && `req_valid` && `req_write`) and is then registered by the core.
  - mtime and mtimecmp: `reg_wdata` is the byte-merge of `req_wdata` over the current register value, per `req_wstrb`.
  - Matching `mtime_wen` or `mtimecmp_wen[i]` is 1 only when any strobe is set.
  - msip word k: `reg_wdata` = `req_wdata`.
  - `msip_wen[2k]` = `req_wstrb[0]`; `msip_wen[2k+1]` = `req_wstrb[4]`, gated by 2k+1 < `HART_NUM`.
  - Errored writes produce no strobe.
- **Read** in the accept cycle captures into the response registers:
  - msip word: {31'b0, `msip[2k+1]`, 31'b0, `msip[2k]`}, where a missing odd hart reads 0.
  - mtimecmp[i] / mtime: full 64-bit value.
- **Tick handling:**
  - `rtc_tick` sets `tick_pend`.
  - In any cycle with no bus commit, `tick_pend` → `mtime_wen`=1, `reg_wdata`=`mtime`+1 (mod 2^64, wraps to 0), and `tick_pend` clears. A tick arriving that same cycle re-sets it.
  - Bus commit to mtime: takes priority, and `tick_pend` plus any same-cycle tick are discarded.
  - Bus commit to another register: takes priority, and the tick stays pending.
- Bus commits are at most one per two cycles, so one pending bit is sufficient.

## Timing
- **Reset values:**
  - State IDLE, so `req_ready`=1.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `tick_pend`=0.
  - All wen outputs 0 and `reg_wdata`=0.
- **Latency:** accept at edge N, `rsp_valid` from N+1, write visible in core outputs from N+1.
- `rsp_*` stay stable while `rsp_valid` && !`rsp_ready`.
- **Back-to-back:** the next request is accepted no earlier than the cycle after the response handshake.
- **Tick drain:** a pending tick is applied within at most one cycle of being set. A tick with no contention updates `mtime` one edge after the pulse.
- **Reset mid-transaction:** an in-flight response is dropped and a pending tick is lost.

## Structure
- Shared package `clint_pkg`:
  - Offsets `CLINT_MSIP_BASE`=0x0000, `CLINT_MTIMECMP_BASE`=0x4000, `CLINT_MTIME_OFF`=0xBFF8.
  - Decode-kind enum {MSIP, MTIMECMP, MTIME, ERR}.
- One combinational sub-module, `clint_addr_dec`: `req_addr` → kind, hart index, error.
- FSM, response registers and tick logic stay in the top module.

## Test plan
- Write 0xBFF8, data 0x1234_5678_9ABC_DEF0, strobes 0xFF → `mtime_wen` one cycle with that `reg_wdata`; read back returns the value, `rsp_err`=0.
- `HART_NUM`=2, write 0x0000, wdata 0x1_0000_0001, strobes 0x11 → `msip_wen`=2'b11, both msip=1; read returns 0x0000_0001_0000_0001.
- Write mtimecmp[0] with strobes 0x0F, data 0xAAAA_AAAA_5555_5555, over old value 0xFFFF_FFFF_FFFF_FFFF → `reg_wdata`=0xFFFF_FFFF_5555_5555.
- `mtime`=0xFFFF_FFFF_FFFF_FFFF, `rtc_tick` pulse → next `mtime`=0.
- `rtc_tick` in the same cycle as a mtimecmp commit → `mtime` increments one cycle later. Tick in the same cycle as an mtime write of 5 → `mtime`=5, no increment.
- Read 0x8000, then `HART_NUM`=1 read of mtimecmp[1] at 0x4008 → `rsp_err`=1, `rsp_rdata`=0, no wen. Hold `rsp_ready`=0 for 3 cycles → response stable and `req_ready`=0 throughout.
